us_data_aggregation: RTL and testbench

Upstream counterpart of the downstream per-destination demux. Round-robin arbitrates among `US_CHANNEL` per-channel upstream FIFOs that each hold at least one complete burst. It prepends a 128-bit packet header carrying the channel's source ID, then streams that burst as 128-bit beats onto the single upstream link. Sits between the per-channel upstream FIFOs and the upstream packet FIFO/framer.

---
 rtl/us_data_aggregation.sv | 147 ++++++++++++++
 tb/tb_us_data_aggregation.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/us_data_aggregation.sv
// Round-robin merge of the per-channel upstream FIFOs onto a single 128-bit link;
// each burst is preceded by one header beat carrying the channel's source ID.
module us_data_aggregation #(
  parameter int                        US_CHANNEL  = 8,
  parameter int                        BURST_BEATS = 16,
  parameter logic [8*US_CHANNEL-1:0]   CH_ID_TABLE = {8'h10, 8'h11, 8'h1c, 8'h1b,
                                                      8'h1a, 8'h19, 8'h18, 8'h17},
  parameter logic [7:0]                HOST_ID     = 8'h01,
  parameter logic [7:0]                DATA_TYPE   = 8'h02
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic [US_CHANNEL-1:0]     us_burst_ready_i,
  input  logic [US_CHANNEL*128-1:0] us_fifo_dout_i,
  output logic [US_CHANNEL-1:0]     us_fifo_rd_en_o,
  input  logic                      us_burst_prog_full_i,
  output logic                      us_burst_valid_o,
  output logic [127:0]              us_burst_data_o,
  output logic                      us_burst_sop_o,
  output logic                      us_burst_eop_o,
  output logic [31:0]               us_burst_cnt_o
);

  localparam int GW = (US_CHANNEL > 1) ? $clog2(US_CHANNEL) : 1;
  localparam int BW = $clog2(BURST_BEATS);
  localparam logic [GW-1:0] LAST_CH   = GW'(US_CHANNEL - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
  localparam logic [15:0]   BYTE_LEN  = 16'(BURST_BEATS * 16);

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, DATA = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic [127:0]    data_q, data_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [GW-1:0]   pick_s;
  logic [127:0]    header_s;

  // First requesting channel after `last`, wrapping; `last` itself is checked last.
  function automatic logic [GW-1:0] rr_pick(input logic [US_CHANNEL-1:0] req,
                                            input logic [GW-1:0] last);
    logic found;
    int   idx;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= US_CHANNEL; i++) begin
      idx = (int'(last) + i) % US_CHANNEL;
      if (!found && req[idx]) begin
        rr_pick = GW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  assign pick_s   = rr_pick(us_burst_ready_i, last_grant_q);
  assign header_s = {CH_ID_TABLE[{grant_q, 3'd0} +: 8], HOST_ID, DATA_TYPE,
                     8'(grant_q), BYTE_LEN, 80'h0};

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    valid_d      = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    data_d       = 128'h0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if ((|us_burst_ready_i) && !us_burst_prog_full_i) begin
          grant_d      = pick_s;
          last_grant_d = pick_s;
          beat_cnt_d   = '0;
          state_d      = HEAD;
        end else begin
          state_d = IDLE;
        end
      end
      HEAD: begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        data_d  = header_s;
        state_d = DATA;
      end
      DATA: begin
        valid_d    = 1'b1;
        data_d     = us_fifo_dout_i[{grant_q, 7'd0} +: 128];
        beat_cnt_d = beat_cnt_q + BW'(1);
        if (beat_cnt_q == LAST_BEAT) begin
          eop_d   = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop is decoded straight from state so it drops in the very cycle reset is sampled.
  always_comb begin
    us_fifo_rd_en_o = '0;
    if (state_q == DATA && !rst_i) begin
      us_fifo_rd_en_o[grant_q] = 1'b1;
    end else begin
      us_fifo_rd_en_o = '0;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      beat_cnt_q   <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      data_q       <= 128'h0;
      cnt_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign us_burst_valid_o = valid_q;
  assign us_burst_sop_o   = sop_q;
  assign us_burst_eop_o   = eop_q;
  assign us_burst_data_o  = data_q;
  assign us_burst_cnt_o   = cnt_q;

endmodule

// File: tb/tb_us_data_aggregation.sv
// Bench for us_data_aggregation: FIFO model per channel, scoreboard of expected
// output beats, table of arbitration scenarios plus hand-written corner cases.
module tb_us_data_aggregation;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     ready;
  logic [1023:0]  dout;
  logic [7:0]     rd_en;
  logic           prog_full;
  logic           valid, sop, eop;
  logic [127:0]   data;
  logic [31:0]    cnt;

  us_data_aggregation dut (
    .sys_clk_i            (clk),
    .rst_i                (rst),
    .us_burst_ready_i     (ready),
    .us_fifo_dout_i       (dout),
    .us_fifo_rd_en_o      (rd_en),
    .us_burst_prog_full_i (prog_full),
    .us_burst_valid_o     (valid),
    .us_burst_data_o      (data),
    .us_burst_sop_o       (sop),
    .us_burst_eop_o       (eop),
    .us_burst_cnt_o       (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } beat_t;

  typedef struct {
    logic            do_rst;
    logic [7:0]      rdy;
    int              n;
    logic [8:0][3:0] g;
  } vec_t;

  beat_t      sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         fptr[8] = '{default: 0};
  int         exp_ptr[8] = '{default: 0};
  logic [31:0] exp_cnt = 32'h0;
  int         sop_seen = 0;
  int         cyc = 0;
  int         last_eop = 0;
  logic       chk_gap = 1'b0;
  logic [7:0] ids[8] = '{8'h17, 8'h18, 8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h11, 8'h10};

  function automatic logic [127:0] word(input int ch, input int idx);
    return {64'hDEAD_BEEF_0000_0000, 48'h0, 8'(ch), 8'(idx)};
  endfunction

  function automatic logic [127:0] hdr(input int g);
    return {ids[g], 8'h01, 8'h02, 8'(g), 16'h0100, 80'h0};
  endfunction

  task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FWFT FIFO heads and pops
  always_comb begin
    for (int i = 0; i < 8; i++) dout[128*i +: 128] = word(i, fptr[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (rd_en[i]) fptr[i] <= fptr[i] + 1;
  end

  // Output monitor / scoreboard
  always @(posedge clk) begin
    beat_t b;
    #1;
    cyc++;
    chk("rd_en_onehot", 130'($countones(rd_en) <= 1), 130'd1);
    if (valid) begin
      if (sop) begin
        if (chk_gap && sop_seen > 0) chk("b2b_gap", 130'(cyc - last_eop), 130'd2);
        sop_seen++;
      end
      if (eop) last_eop = cyc;
      chk("beat_expected", 130'(sb.size() != 0), 130'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        chk("beat", {sop, eop, data}, {b.sop, b.eop, b.data});
      end
    end else begin
      chk("idle_zero", {sop, eop, data}, 130'd0);
    end
  end

  task automatic push_burst(input int g);
    beat_t b;
    b.data = hdr(g); b.sop = 1'b1; b.eop = 1'b0;
    sb.push_back(b);
    for (int k = 0; k < 16; k++) begin
      b.data = word(g, exp_ptr[g] + k); b.sop = 1'b0; b.eop = (k == 15);
      sb.push_back(b);
    end
    exp_ptr[g] += 16;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 32'h0;
  endtask

  task automatic wait_sop(input int n);
    int b = 0;
    while (sop_seen < n && b < 400) begin
      @(posedge clk); #2; b++;
    end
    chk("sop_timeout", 130'(sop_seen >= n), 130'd1);
  endtask

  task automatic wait_empty();
    int b = 0;
    while (sb.size() != 0 && b < 100) begin
      @(posedge clk); #2; b++;
    end
    chk("drain_timeout", 130'(sb.size()), 130'd0);
  endtask

  task automatic check_pops_cnt();
    for (int c = 0; c < 8; c++) chk($sformatf("pops_ch%0d", c), 130'(fptr[c]), 130'(exp_ptr[c]));
    chk("burst_cnt", 130'(cnt), 130'(exp_cnt));
  endtask

  task automatic run_bursts(input logic [7:0] rdy, input int n, input logic [8:0][3:0] g);
    for (int k = 0; k < n; k++) push_burst(int'(g[k]));
    sop_seen  = 0;
    chk_gap   = 1'b1;
    prog_full = 1'b1;
    ready     = rdy;
    prog_full = 1'b0;
    wait_sop(n);
    prog_full = 1'b1;
    wait_empty();
    repeat (4) @(posedge clk);
    #2;
    chk_gap = 1'b0;
    ready   = 8'h0;
    check_pops_cnt();
  endtask

  initial begin
    vec_t tbl[5];
    beat_t b;
    tbl[0] = '{1'b1, 8'h04, 1, 36'h2};
    tbl[1] = '{1'b1, 8'hFF, 9, 36'h0_7654_3210};
    tbl[2] = '{1'b0, 8'h81, 3, 36'h707};
    tbl[3] = '{1'b0, 8'h30, 3, 36'h454};
    tbl[4] = '{1'b0, 8'h09, 3, 36'h030};

    rst = 1'b1; ready = 8'h0; prog_full = 1'b1;
    do_reset();
    chk("reset_outputs", {valid, sop, eop, data}, 130'd0);
    chk("reset_cnt", 130'(cnt), 130'd0);
    chk("reset_rd_en", 130'(rd_en), 130'd0);

    for (int r = 0; r < 5; r++) begin
      if (tbl[r].do_rst) do_reset();
      run_bursts(tbl[r].rdy, tbl[r].n, tbl[r].g);
    end

    // Backpressure holds off a ready channel; header lands two cycles after release
    ready = 8'h01; prog_full = 1'b1;
    repeat (10) begin
      @(posedge clk); #2;
      chk("pf_no_rd_en", 130'(rd_en), 130'd0);
      chk("pf_no_valid", 130'(valid), 130'd0);
    end
    push_burst(0);
    sop_seen = 0;
    prog_full = 1'b0;
    @(posedge clk); #2;
    chk("pf_head_cycle_quiet", 130'(valid), 130'd0);
    @(posedge clk); #2;
    chk("pf_header_t2", {valid, sop}, 130'b11);
    repeat (3) @(posedge clk);
    #2;
    prog_full = 1'b1;
    wait_empty();
    repeat (10) begin
      @(posedge clk); #2;
      chk("pf_hold_rd_en", 130'(rd_en), 130'd0);
      chk("pf_hold_valid", 130'(valid), 130'd0);
    end
    push_burst(0);
    sop_seen = 0;
    prog_full = 1'b0;
    wait_sop(1);
    prog_full = 1'b1;
    wait_empty();
    ready = 8'h0;
    check_pops_cnt();

    // Reset in the middle of a ch4 burst, at data beat 5
    b.data = hdr(4); b.sop = 1'b1; b.eop = 1'b0;
    sb.push_back(b);
    for (int k = 0; k < 5; k++) begin
      b.data = word(4, exp_ptr[4] + k); b.sop = 1'b0; b.eop = 1'b0;
      sb.push_back(b);
    end
    exp_ptr[4] += 5;
    sop_seen = 0;
    ready = 8'h10;
    prog_full = 1'b0;
    wait_sop(1);
    prog_full = 1'b1;
    ready = 8'h0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_rd_en", 130'(rd_en), 130'd0);
    @(posedge clk); #2;
    chk("abort_outputs", {valid, sop, eop, data}, 130'd0);
    chk("abort_cnt", 130'(cnt), 130'd0);
    chk("abort_sb_empty", 130'(sb.size()), 130'd0);
    rst = 1'b0;
    exp_cnt = 32'h0;
    run_bursts(8'h11, 2, 36'h40);

    // Counter wrap via preload
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.cnt_q;
    @(posedge clk); #2;
    chk("cnt_preload", 130'(cnt), 130'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    run_bursts(8'h01, 1, 36'h0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
